serial_alu: RTL

SERIAL_ALU -- requirements
Module: serial_alu

---
 rtl/serial_alu_if.sv | 28 ++
 rtl/serial_alu.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/serial_alu_if.sv
// serial_alu_if -- handshake and operand/result bundle for serial_alu.
//   start/op/a/b (+cin when SERIAL_ALU_CIN_EN is defined) : requester -> ALU
//   busy/done/result/cout/zero                             : ALU -> requester
// Modports: master (requester side), slave (ALU side).
interface serial_alu_if #(
   parameter int unsigned WORD = 4
);
   logic            start;
   logic [2:0]      op;
   logic [WORD-1:0] a;
   logic [WORD-1:0] b;
`ifdef SERIAL_ALU_CIN_EN
   logic            cin;
`endif
   logic            busy;
   logic            done;
   logic [WORD-1:0] result;
   logic            cout;
   logic            zero;

`ifdef SERIAL_ALU_CIN_EN
   modport master (output start, op, a, b, cin, input busy, done, result, cout, zero);
   modport slave  (input start, op, a, b, cin, output busy, done, result, cout, zero);
`else
   modport master (output start, op, a, b, input busy, done, result, cout, zero);
   modport slave  (input start, op, a, b, output busy, done, result, cout, zero);
`endif
endinterface

// File: rtl/serial_alu.sv
// serial_alu -- bit-serial ALU, one operand bit per clock, LSB first.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : serial_alu_if.slave (start/op/a/b in, busy/done/result/cout/zero out)
// Opcodes: 0 XOR, 1 OR, 2 AND, 3 GT (a>b unsigned), 4 ADD, 5 SUB, 6 PASS B, 7 EQ.
// An accepted start is followed by WORD processing edges; the last one
// updates result/cout/zero, drops busy and pulses done.
// Optional macro SERIAL_ALU_CIN_EN adds bus.cin, the carry/borrow seed for ADD/SUB.
module serial_alu #(
   parameter int unsigned WORD = 4
) (
   input logic        clk,
   input logic        rst,
   serial_alu_if.slave bus
);

   localparam int unsigned CW = (WORD > 1) ? $clog2(WORD) : 1;

   typedef enum logic [2:0] {
      OP_XOR  = 3'd0,
      OP_OR   = 3'd1,
      OP_AND  = 3'd2,
      OP_GT   = 3'd3,
      OP_ADD  = 3'd4,
      OP_SUB  = 3'd5,
      OP_PASS = 3'd6,
      OP_EQ   = 3'd7
   } op_t;

   typedef enum logic {
      S_IDLE,
      S_RUN
   } state_t;

   state_t          state;
   op_t             opr;
   op_t             op_in;
   logic [WORD-1:0] sa;
   logic [WORD-1:0] sb;
   logic [WORD-1:0] acc;
   logic [CW-1:0]   cnt;
   logic            chain;
   logic            seed;
   logic            chain_init;

   logic            busy_r;
   logic            done_r;
   logic [WORD-1:0] result_r;
   logic            cout_r;
   logic            zero_r;

   logic            ai;
   logic            bi;
   logic            obit;
   logic            nchain;
   logic [WORD-1:0] assembled;
   logic [WORD-1:0] final_res;

`ifdef SERIAL_ALU_CIN_EN
   assign seed = bus.cin;
`else
   assign seed = 1'b0;
`endif

   assign op_in = op_t'(bus.op);

   // Chain seed at accept: EQ starts "equal so far", ADD/SUB take the optional
   // carry/borrow-in, everything else starts clear.
   always_comb begin
      chain_init = 1'b0;
      case (op_in)
         OP_EQ:          chain_init = 1'b1;
         OP_ADD, OP_SUB: chain_init = seed;
         default:        chain_init = 1'b0;
      endcase
   end

   assign ai = sa[0];
   assign bi = sb[0];

   // 1-bit slice: output bit and next chain value for the current bit.
   always_comb begin
      obit   = 1'b0;
      nchain = chain;
      case (opr)
         OP_XOR:  obit = ai ^ bi;
         OP_OR:   obit = ai | bi;
         OP_AND:  obit = ai & bi;
         OP_PASS: obit = bi;
         OP_ADD: begin
            obit   = ai ^ bi ^ chain;
            nchain = (ai & bi) | (chain & (ai ^ bi));
         end
         OP_SUB: begin
            obit   = ai ^ bi ^ chain;
            nchain = (~ai & bi) | (~(ai ^ bi) & chain);
         end
         // GT scans LSB first, so a higher differing bit overrides the lower verdict.
         OP_GT:   nchain = (ai & ~bi) | (~(ai ^ bi) & chain);
         OP_EQ:   nchain = chain & ~(ai ^ bi);
         default: begin
            obit   = 1'b0;
            nchain = chain;
         end
      endcase
   end

   // Output bits enter at the MSB and migrate down, landing in place after WORD shifts.
   assign assembled = {obit, acc[WORD-1:1]};
   assign final_res = ((opr == OP_GT) || (opr == OP_EQ)) ?
                      {{(WORD-1){1'b0}}, nchain} : assembled;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         opr      <= OP_XOR;
         sa       <= '0;
         sb       <= '0;
         acc      <= '0;
         cnt      <= '0;
         chain    <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         result_r <= '0;
         cout_r   <= 1'b0;
         zero_r   <= 1'b1;
      end else begin
         done_r <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  opr    <= op_in;
                  sa     <= bus.a;
                  sb     <= bus.b;
                  acc    <= '0;
                  cnt    <= '0;
                  chain  <= chain_init;
                  busy_r <= 1'b1;
                  state  <= S_RUN;
               end
            end
            S_RUN: begin
               sa    <= sa >> 1;
               sb    <= sb >> 1;
               acc   <= assembled;
               chain <= nchain;
               cnt   <= cnt + 1'b1;
               if (cnt == CW'(WORD - 1)) begin
                  result_r <= final_res;
                  cout_r   <= nchain;
                  zero_r   <= (final_res == '0);
                  busy_r   <= 1'b0;
                  done_r   <= 1'b1;
                  state    <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy   = busy_r;
   assign bus.done   = done_r;
   assign bus.result = result_r;
   assign bus.cout   = cout_r;
   assign bus.zero   = zero_r;

endmodule
